// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte-stream, instruction-memory write and status signals of the boot loader
interface imem_loader_if #(
  parameter int ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              reload;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_reset;
  logic              load_done;
  logic [1:0]        err_code;
  logic [15:0]       words_loaded;

  modport slave (
    input  rx_data, rx_valid, reload,
    output rx_ready, imem_we, imem_addr, imem_wdata,
           core_reset, load_done, err_code, words_loaded
  );

  modport master (
    output rx_data, rx_valid, reload,
    input  rx_ready, imem_we, imem_addr, imem_wdata,
           core_reset, load_done, err_code, words_loaded
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - boot loader: length-prefixed byte stream to big-endian imem words, XOR-verified
module imem_loader #(
  parameter int ADDR_W  = 10,
  parameter int TIMEOUT = 1000
) (
  input logic          clk,
  input logic          reset,
  imem_loader_if.slave io
);
  localparam int          TW    = $clog2(TIMEOUT + 1);
  localparam logic [16:0] DEPTH = 17'(1) << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_LO, S_DATA, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t            state_q;
  logic [15:0]       len_q;
  logic [7:0]        xor_q;
  logic [23:0]       asm_q;
  logic [1:0]        byte_cnt_q;
  logic [TW-1:0]     timer_q;
  logic              rx_ready_q;
  logic              imem_we_q;
  logic [ADDR_W-1:0] imem_addr_q;
  logic [31:0]       imem_wdata_q;
  logic              core_reset_q;
  logic              load_done_q;
  logic [1:0]        err_q;
  logic [15:0]       words_q;

  // reload wins over a byte offered in the same cycle
  logic        xfer;
  logic [15:0] len_n;
  logic [15:0] words_inc;
  assign xfer      = io.rx_valid && rx_ready_q && !io.reload;
  assign len_n     = {len_q[15:8], io.rx_data};
  assign words_inc = words_q + 16'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      len_q        <= '0;
      xor_q        <= '0;
      asm_q        <= '0;
      byte_cnt_q   <= '0;
      timer_q      <= '0;
      rx_ready_q   <= 1'b1;
      imem_we_q    <= 1'b0;
      imem_addr_q  <= '0;
      imem_wdata_q <= '0;
      core_reset_q <= 1'b1;
      load_done_q  <= 1'b0;
      err_q        <= 2'b00;
      words_q      <= '0;
    end else begin
      imem_we_q <= 1'b0;
      if (io.reload) begin
        state_q      <= S_IDLE;
        xor_q        <= '0;
        asm_q        <= '0;
        byte_cnt_q   <= '0;
        timer_q      <= '0;
        rx_ready_q   <= 1'b1;
        imem_addr_q  <= '0;
        core_reset_q <= 1'b1;
        load_done_q  <= 1'b0;
        err_q        <= 2'b00;
        words_q      <= '0;
      end else if (xfer) begin
        timer_q <= '0;
        xor_q   <= xor_q ^ io.rx_data;
        case (state_q)
          S_IDLE: begin
            len_q   <= {io.rx_data, 8'h00};
            state_q <= S_LEN_LO;
          end
          S_LEN_LO: begin
            len_q <= len_n;
            if ({1'b0, len_n} > DEPTH) begin
              state_q    <= S_ERROR;
              err_q      <= 2'b01;
              rx_ready_q <= 1'b0;
            end else if (len_n == 16'd0) begin
              state_q <= S_CHECK;
            end else begin
              state_q <= S_DATA;
            end
          end
          S_DATA: begin
            asm_q      <= {asm_q[15:0], io.rx_data};
            byte_cnt_q <= byte_cnt_q + 2'd1;
            if (byte_cnt_q == 2'd3) begin
              imem_we_q    <= 1'b1;
              imem_addr_q  <= words_q[ADDR_W-1:0];
              imem_wdata_q <= {asm_q, io.rx_data};
              words_q      <= words_inc;
              if (words_inc == len_q) state_q <= S_CHECK;
            end
          end
          S_CHECK: begin
            rx_ready_q <= 1'b0;
            if (io.rx_data == xor_q) begin
              state_q      <= S_DONE;
              load_done_q  <= 1'b1;
              core_reset_q <= 1'b0;
            end else begin
              state_q <= S_ERROR;
              err_q   <= 2'b10;
            end
          end
          default: ;
        endcase
      end else if (state_q inside {S_LEN_LO, S_DATA, S_CHECK}) begin
        // idle cycles only count once a load has started
        if (timer_q == TW'(TIMEOUT - 1)) begin
          state_q    <= S_ERROR;
          err_q      <= 2'b11;
          rx_ready_q <= 1'b0;
        end else begin
          timer_q <= timer_q + 1'b1;
        end
      end
    end
  end

  assign io.rx_ready     = rx_ready_q;
  assign io.imem_we      = imem_we_q;
  assign io.imem_addr    = imem_addr_q;
  assign io.imem_wdata   = imem_wdata_q;
  assign io.core_reset   = core_reset_q;
  assign io.load_done    = load_done_q;
  assign io.err_code     = err_q;
  assign io.words_loaded = words_q;
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized image loads checked against a stream-level loader model
module tb_imem_loader;
  localparam int ADDR_W  = 10;
  localparam int TIMEOUT = 1000;
  localparam int DEPTH   = 1 << ADDR_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  imem_loader_if #(.ADDR_W(ADDR_W)) io ();
  imem_loader #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .reset (reset),
    .io    (io)
  );

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          addr;
    logic [31:0] data;
  } wr_t;

  wr_t         exp_q[$];
  logic [7:0]  stream[$];
  int          we_count = 0;
  logic [31:0] last_wdata = '0;
  bit          mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Every write must be the next expected (address, word); status outputs stay mutually consistent.
  initial begin
    wr_t w;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en) begin
        check("inv_rx_ready", 32'(io.rx_ready), 32'(!(io.load_done || io.err_code != 2'b00)));
        check("inv_release", 32'(io.load_done), 32'(!io.core_reset));
        if (io.imem_we === 1'b1) begin
          we_count++;
          last_wdata = io.imem_wdata;
          if (exp_q.size() == 0) begin
            check("unexpected_write", 32'(io.imem_addr), 32'hFFFF_FFFF);
          end else begin
            w = exp_q.pop_front();
            check("wr_addr", 32'(io.imem_addr), w.addr);
            check("wr_data", io.imem_wdata, w.data);
            check("wr_words_loaded", 32'(io.words_loaded), w.addr + 1);
          end
        end
      end
    end
  end

  task automatic build_image(input int n, input bit bad);
    logic [31:0] w;
    logic [7:0]  cs;
    wr_t         e;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    for (int i = 0; i < n; i++) begin
      w = $urandom;
      for (int b = 3; b >= 0; b--) stream.push_back(8'(w >> (8 * b)));
      e.addr = i;
      e.data = w;
      exp_q.push_back(e);
    end
    cs = 8'h00;
    foreach (stream[i]) cs ^= stream[i];
    if (bad) cs ^= 8'($urandom_range(1, 255));
    stream.push_back(cs);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit ok;
    bit rdy;
    repeat (gap) begin
      io.rx_valid = 1'b0;
      @(negedge clk);
    end
    io.rx_valid = 1'b1;
    io.rx_data  = b;
    ok = 1'b0;
    for (int n = 0; n < 32; n++) begin
      rdy = io.rx_ready;
      @(posedge clk);
      @(negedge clk);
      if (rdy) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("byte_stalled", 32'(b), 32'hFFFF_FFFF);
  endtask

  // gapmode 0: back-to-back; 1: random short gaps; 2: maximal legal gap before the checksum
  task automatic send_stream(input int count, input int gapmode);
    int gap;
    for (int i = 0; i < count; i++) begin
      gap = 0;
      if (gapmode == 1)
        gap = ($urandom_range(0, 299) == 0) ? TIMEOUT - 1 : int'($urandom_range(0, 2));
      else if (gapmode == 2 && i == stream.size() - 1)
        gap = TIMEOUT - 1;
      send_byte(stream[i], gap);
      if (i >= 2 && i < stream.size() - 1 && (i - 2) % 4 == 3)
        check("we_after_4th_byte", 32'(io.imem_we), 1);
    end
    io.rx_valid = 1'b0;
  endtask

  task automatic finish_good(input int n);
    check("done_load_done", 32'(io.load_done), 1);
    check("done_core_reset", 32'(io.core_reset), 0);
    check("done_err_code", 32'(io.err_code), 0);
    check("done_words", 32'(io.words_loaded), n);
    check("done_rx_ready", 32'(io.rx_ready), 0);
    check("done_pending_writes", exp_q.size(), 0);
  endtask

  task automatic finish_bad(input int n, input int code);
    check("err_code", 32'(io.err_code), code);
    check("err_core_reset", 32'(io.core_reset), 1);
    check("err_load_done", 32'(io.load_done), 0);
    check("err_rx_ready", 32'(io.rx_ready), 0);
    check("err_words", 32'(io.words_loaded), n);
    check("err_pending_writes", exp_q.size(), 0);
  endtask

  task automatic reload_pulse(input bit with_byte);
    io.reload   = 1'b1;
    io.rx_valid = with_byte;
    io.rx_data  = 8'($urandom);
    @(posedge clk);
    @(negedge clk);
    io.reload   = 1'b0;
    io.rx_valid = 1'b0;
    exp_q.delete();
    check("reload_core_reset", 32'(io.core_reset), 1);
    check("reload_load_done", 32'(io.load_done), 0);
    check("reload_err_code", 32'(io.err_code), 0);
    check("reload_words", 32'(io.words_loaded), 0);
    check("reload_rx_ready", 32'(io.rx_ready), 1);
    check("reload_imem_addr", 32'(io.imem_addr), 0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int wc;
    int n;
    bit bad;
    reset       = 1'b1;
    io.rx_data  = 8'h00;
    io.rx_valid = 1'b0;
    io.reload   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rx_ready", 32'(io.rx_ready), 1);
    check("rst_imem_we", 32'(io.imem_we), 0);
    check("rst_imem_addr", 32'(io.imem_addr), 0);
    check("rst_imem_wdata", io.imem_wdata, 0);
    check("rst_core_reset", 32'(io.core_reset), 1);
    check("rst_load_done", 32'(io.load_done), 0);
    check("rst_err_code", 32'(io.err_code), 0);
    check("rst_words", 32'(io.words_loaded), 0);
    reset = 1'b0;
    @(negedge clk);
    mon_en = 1'b1;

    // literal one-word image
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    exp_q.push_back('{addr: 0, data: 32'h1234_5678});
    send_stream(stream.size(), 0);
    finish_good(1);
    check("lit_wdata", last_wdata, 32'h1234_5678);
    check("lit_we_count", we_count, 1);

    reload_pulse(1'b1);
    stream = '{8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h0A};
    exp_q.push_back('{addr: 0, data: 32'h1234_5678});
    send_stream(stream.size(), 0);
    finish_bad(1, 2);
    check("badcs_we_count", we_count, 2);

    reload_pulse(1'b0);
    stream = '{8'h04, 8'h01};
    send_stream(2, 0);
    finish_bad(0, 1);
    repeat (5) @(negedge clk);
    check("toolong_no_write", we_count, 2);

    reload_pulse(1'b0);
    stream = '{8'h00, 8'h02, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    exp_q.push_back('{addr: 0, data: 32'hAABB_CCDD});
    send_stream(stream.size(), 0);
    repeat (TIMEOUT - 1) @(negedge clk);
    check("timeout_not_yet", 32'(io.err_code), 0);
    check("timeout_not_yet_ready", 32'(io.rx_ready), 1);
    @(negedge clk);
    finish_bad(1, 3);
    check("timeout_we_count", we_count, 3);

    reload_pulse(1'b0);
    stream = '{8'h00, 8'h00, 8'h00};
    send_stream(3, 0);
    finish_good(0);
    check("empty_we_count", we_count, 3);

    // reload while a byte is offered mid-image, then a fresh two-word image
    reload_pulse(1'b1);
    build_image(3, 1'b0);
    send_stream(7, 0);
    reload_pulse(1'b1);
    build_image(2, 1'b0);
    wc = we_count;
    send_stream(stream.size(), 2);
    finish_good(2);
    check("two_word_we_count", we_count - wc, 2);

    reload_pulse(1'b0);
    build_image(DEPTH, 1'b0);
    send_stream(stream.size(), 0);
    finish_good(DEPTH);

    for (int t = 0; t < 25; t++) begin
      reload_pulse(1'($urandom_range(0, 1)));
      n   = $urandom_range(0, 12);
      bad = ($urandom_range(0, 3) == 0);
      build_image(n, bad);
      send_stream(stream.size(), 1);
      if (bad) finish_bad(n, 2);
      else     finish_good(n);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that sits upstream of the pipeline's instruction memory. It receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words, writing them into instruction memory at word addresses 0, 1, 2, …. The stream is verified with an XOR checksum. While loading, and after any failure, the block holds the core in reset. It releases the core only after a complete, valid image has been written.

## Interface
- ADDR_W, 10, instruction-memory word-address width; DEPTH = 2**ADDR_W words
- TIMEOUT, 1000, max idle cycles between accepted bytes once a load has started

- clk  input  1  clock
- reset  input  1  asynchronous, active-high
- rx_data  input  8  incoming byte
- rx_valid  input  1  rx_data valid
- rx_ready  output  1  loader can accept a byte
- reload  input  1  single-cycle pulse; restart the load sequence
- imem_we  output  1  instruction-memory write strobe, one cycle per word
- imem_addr  output  ADDR_W  word address of the write
- imem_wdata  output  32  word to write
- core_reset  output  1  high = hold pipeline in reset
- load_done  output  1  image loaded and verified
- err_code  output  2  00 none, 01 image too long, 10 checksum mismatch, 11 timeout
- words_loaded  output  16  count of words written so far

## Operation
- Stream format, in order:
  - N: word count, 16-bit, high byte first.
  - N×4 data bytes, each word MSB first.
  - One checksum byte: the XOR of every preceding byte, including both length bytes.
- Byte transfer happens when rx_valid && rx_ready at a posedge.
- States:
  - IDLE: waits for the length high byte. Accepting it → LEN_LO.
  - LEN_LO: accepting the length low byte → one of:
    - ERROR (err_code 01) if N > DEPTH;
    - CHECK if N == 0;
    - DATA otherwise.
  - DATA: shifts bytes into a 32-bit assembly register. On the 4th byte of a word:
    - issues a write;
    - increments words_loaded;
    - → CHECK after word N, otherwise stays in DATA.
  - CHECK: accepting the checksum byte → DONE if it equals the running XOR, else ERROR (err_code 10).
  - DONE: load_done=1, core_reset=0.
  - ERROR: core_reset=1, load_done=0; err_code is held.
- Timeout:
  - A counter runs in LEN_LO, DATA and CHECK. It clears on every accepted byte and on state entry.
  - Reaching TIMEOUT → ERROR, err_code 11.
  - No timeout in IDLE, DONE or ERROR.
- reload, from any state:
  - next state IDLE; core_reset=1, load_done=0;
  - err_code, words_loaded, running XOR and assembly register cleared; imem_addr=0.
  - reload has priority over a byte transfer in the same cycle; that byte is not accepted.
- rx_ready = 1 in IDLE, LEN_LO, DATA and CHECK; rx_ready = 0 in DONE and ERROR.
- Bytes arriving while rx_ready=0 are ignored; the sender holds them.
- Instruction memory is never written outside DATA, so a second load overwrites from address 0.

## Timing
- All outputs are registered.
- Reset values:
  - state IDLE, rx_ready=1, imem_we=0, imem_addr=0, imem_wdata=0;
  - core_reset=1, load_done=0, err_code=00, words_loaded=0.
- Word write: the 4th byte of word i is accepted at edge k. In the cycle after edge k:
  - imem_we=1 for exactly one cycle;
  - imem_addr=i, imem_wdata=assembled word;
  - words_loaded=i+1.
- Release:
  - A correct checksum byte accepted at edge k → load_done=1 and core_reset=0 in the cycle after k.
  - The last imem_we is at least one cycle earlier than this, so no write is outstanding at release.
- Error: err_code and core_reset=1 are visible in the cycle after the failing event (byte edge or timeout edge).
- Throughput: one byte per cycle with rx_valid held high; no bubbles between words.
- Asynchronous reset mid-load aborts immediately: core_reset=1, and partially written memory content is undefined.

## Test plan
- Stream 00 01 12 34 56 78 09 at one byte per cycle:
  - one imem_we with addr 0, wdata 0x12345678;
  - load_done=1 and core_reset=0 one cycle after the 0x09 byte;
  - err_code 00, words_loaded 1.
- Same stream with checksum 0x0A:
  - imem_we for word 0 still occurs;
  - then ERROR, err_code 10, core_reset stays 1, rx_ready=0.
- Length 04 01 (N=1025, ADDR_W=10) → ERROR, err_code 01 after the second byte; no imem_we ever asserted.
- Stream 00 02 followed by 5 data bytes, then rx_valid low for TIMEOUT cycles:
  - exactly one write occurred;
  - err_code 11 appears after the timeout.
- Stream 00 00 00 → DONE with no writes, words_loaded 0.
- After a DONE:
  - pulse reload in the same cycle rx_valid=1: that byte is not accepted;
  - state is IDLE with core_reset=1;
  - a new two-word image writes addresses 0 and 1 again and releases the core.
- Random rx_valid gaps shorter than TIMEOUT: write sequence and release are identical to the gap-free case.
